// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// funct3 width codes, FSM states and response error codes.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_MISAL   = 2'b01,
      ERR_ILLEGAL = 2'b10,
      ERR_TIMEOUT = 2'b11
   } rsp_err_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
// In: funct3, lo (addr[1:0]), is_load/is_store, wdata, rdata.
// Out: be, wdata_rep, rdata_fmt, misal, illegal.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lo,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_fmt,
   output logic        misal,
   output logic        illegal
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata[{lo, 3'b000} +: 8];
   assign half_sel = lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      be        = 4'b1111;
      wdata_rep = '0;
      if (is_store) begin
         case (funct3)
            F3_SB: begin
               be        = 4'b0001 << lo;
               wdata_rep = {4{wdata[7:0]}};
            end
            F3_SH: begin
               be        = 4'b0011 << {lo[1], 1'b0};
               wdata_rep = {2{wdata[15:0]}};
            end
            F3_SW: begin
               be        = 4'b1111;
               wdata_rep = wdata;
            end
            default: begin
               be        = 4'b0000;
               wdata_rep = '0;
            end
         endcase
      end
   end

   always_comb begin
      rdata_fmt = '0;
      case (funct3)
         F3_LB:  rdata_fmt = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:  rdata_fmt = {{16{half_sel[15]}}, half_sel};
         F3_LW:  rdata_fmt = rdata;
         F3_LBU: rdata_fmt = {24'h0, byte_sel};
         F3_LHU: rdata_fmt = {16'h0, half_sel};
         default: rdata_fmt = '0;
      endcase
   end

   // Halfword codes share funct3[1:0]=01, word codes 10, for loads and stores.
   assign misal = ((funct3[1:0] == 2'b01) && lo[0])
                | ((funct3[1:0] == 2'b10) && (lo != 2'b00));

   assign illegal = (is_load == is_store)
                  | (is_load && ((funct3 == 3'b011)
                              || (funct3 == 3'b110)
                              || (funct3 == 3'b111)))
                  | (is_store && (funct3 > 3'b010));

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit: one data-memory access at a time over req/ack,
// with formatted load data or an error code returned via valid/ready.
// Ports: clk, rst_n; req_valid/req_ready, is_load, is_store, funct3,
// addr, wdata (execute); mem_req/we/addr/be/wdata, mem_ack/rdata (dmem);
// rsp_valid/rsp_ready, rsp_rdata, rsp_err (writeback).
module lsu_dmem_ctrl
   import lsu_pkg::*;
#(
   parameter int DMEM_AW = 5,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               is_load,
   input  logic               is_store,
   input  logic [2:0]         funct3,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic               mem_req,
   output logic               mem_we,
   output logic [DMEM_AW-1:0] mem_addr,
   output logic [3:0]         mem_be,
   output logic [31:0]        mem_wdata,
   input  logic               mem_ack,
   input  logic [31:0]        mem_rdata,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [31:0]        rsp_rdata,
   output logic [1:0]         rsp_err
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         f3_q, f3_d;
   logic [1:0]         lo_q, lo_d;
   logic               mem_req_d, mem_we_d;
   logic [DMEM_AW-1:0] mem_addr_d;
   logic [3:0]         mem_be_d;
   logic [31:0]        mem_wdata_d;
   logic               rsp_valid_d;
   logic [31:0]        rsp_rdata_d;
   rsp_err_t           rsp_err_q, rsp_err_d;

   logic [2:0]  al_f3;
   logic [1:0]  al_lo;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic        al_misal;
   logic        al_illegal;
   logic        tmo_hit;
   logic        unused_addr;

   assign unused_addr = ^addr[31:DMEM_AW+2];

   // The request fields only matter while idle; during BUS the latched
   // width and lane drive load formatting.
   assign al_f3 = (state_q == S_IDLE) ? funct3 : f3_q;
   assign al_lo = (state_q == S_IDLE) ? addr[1:0] : lo_q;

   lsu_lane_align u_align (
      .funct3    (al_f3),
      .lo        (al_lo),
      .is_load   (is_load),
      .is_store  (is_store),
      .wdata     (wdata),
      .rdata     (mem_rdata),
      .be        (al_be),
      .wdata_rep (al_wdata),
      .rdata_fmt (al_rdata),
      .misal     (al_misal),
      .illegal   (al_illegal)
   );

   assign req_ready = (state_q == S_IDLE);
   assign rsp_err   = rsp_err_q;
   assign tmo_hit   = (TIMEOUT != 0)
                   && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      f3_d        = f3_q;
      lo_d        = lo_q;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_be_d    = mem_be;
      mem_wdata_d = mem_wdata;
      rsp_valid_d = rsp_valid;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               f3_d        = funct3;
               lo_d        = addr[1:0];
               rsp_rdata_d = '0;
               if (al_illegal) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = ERR_ILLEGAL;
               end else if (al_misal) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = ERR_MISAL;
               end else begin
                  state_d     = S_BUS;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = is_store;
                  mem_addr_d  = addr[DMEM_AW+1:2];
                  mem_be_d    = al_be;
                  mem_wdata_d = al_wdata;
               end
            end
         end
         S_BUS: begin
            if (mem_ack) begin
               state_d     = S_RESP;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = ERR_OK;
               rsp_rdata_d = mem_we ? 32'h0 : al_rdata;
            end else if (tmo_hit) begin
               state_d     = S_RESP;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = ERR_TIMEOUT;
               rsp_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               cnt_d       = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         f3_q      <= '0;
         lo_q      <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err_q <= ERR_OK;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         f3_q      <= f3_d;
         lo_q      <= lo_d;
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_be    <= mem_be_d;
         mem_wdata <= mem_wdata_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err_q <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed bench for lsu_dmem_ctrl.
// Drives and samples 1 time unit after each rising edge.
module tb_lsu_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_req;
   logic        mem_we;
   logic [4:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lsu_dmem_ctrl #(
      .DMEM_AW (5),
      .TIMEOUT (15),
      .CNT_W   (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .is_load   (is_load),
      .is_store  (is_store),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic st,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd);
      req_valid = 1'b1;
      is_load   = ld;
      is_store  = st;
      funct3    = f3;
      addr      = a;
      wdata     = wd;
      tick();
      req_valid = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
   endtask

   task automatic ack_with(input logic [31:0] rd);
      mem_ack   = 1'b1;
      mem_rdata = rd;
      tick();
      mem_ack   = 1'b0;
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("hs_valid", rsp_valid, 0);
      chk("hs_ready", req_ready, 1);
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      funct3    = 3'b000;
      addr      = '0;
      wdata     = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_rsp_err", rsp_err, 0);
      rst_n = 1'b1;
      tick();

      // SW, ack two cycles after mem_req
      issue(0, 1, 3'b010, 32'h0000_0048, 32'hDEAD_BEEF);
      chk("sw_req", mem_req, 1);
      chk("sw_we", mem_we, 1);
      chk("sw_addr", mem_addr, 5'h12);
      chk("sw_be", mem_be, 4'b1111);
      chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("sw_rdy", req_ready, 0);
      tick();
      chk("sw_hold_req", mem_req, 1);
      tick();
      ack_with(32'h1234_5678);
      chk("sw_req_drop", mem_req, 0);
      chk("sw_valid", rsp_valid, 1);
      chk("sw_err", rsp_err, 0);
      chk("sw_rdata", rsp_rdata, 0);
      handshake();

      // LB / LBU / LH / LHU at minimum latency
      issue(1, 0, 3'b000, 32'h3, 32'h0);
      chk("lb_req", mem_req, 1);
      chk("lb_we", mem_we, 0);
      chk("lb_be", mem_be, 4'b1111);
      chk("lb_wdata", mem_wdata, 0);
      ack_with(32'h80FF_0000);
      chk("lb_valid", rsp_valid, 1);
      chk("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
      handshake();
      issue(1, 0, 3'b100, 32'h3, 32'h0);
      ack_with(32'h80FF_0000);
      chk("lbu_rdata", rsp_rdata, 32'h0000_0080);
      handshake();
      issue(1, 0, 3'b001, 32'h2, 32'h0);
      ack_with(32'h80FF_0000);
      chk("lh_rdata", rsp_rdata, 32'hFFFF_80FF);
      handshake();
      issue(1, 0, 3'b101, 32'h2, 32'h0);
      ack_with(32'h80FF_0000);
      chk("lhu_rdata", rsp_rdata, 32'h0000_80FF);
      handshake();

      // SB / SH lanes
      issue(0, 1, 3'b000, 32'h2, 32'h1234_5678);
      chk("sb_be", mem_be, 4'b0100);
      chk("sb_wdata", mem_wdata, 32'h7878_7878);
      ack_with(32'h0);
      handshake();
      issue(0, 1, 3'b001, 32'h2, 32'h1234_5678);
      chk("sh_be", mem_be, 4'b1100);
      chk("sh_wdata", mem_wdata, 32'h5678_5678);
      ack_with(32'h0);
      handshake();

      // Error paths: no bus activity, rsp_valid at cycle 1
      issue(0, 1, 3'b001, 32'h1, 32'h0);
      chk("mis_req", mem_req, 0);
      chk("mis_valid", rsp_valid, 1);
      chk("mis_err", rsp_err, 2'b01);
      chk("mis_rdata", rsp_rdata, 0);
      tick();
      chk("mis_req2", mem_req, 0);
      handshake();
      issue(1, 0, 3'b110, 32'h0, 32'h0);
      chk("ill_f3_valid", rsp_valid, 1);
      chk("ill_f3_err", rsp_err, 2'b10);
      chk("ill_f3_req", mem_req, 0);
      handshake();
      issue(1, 1, 3'b010, 32'h1, 32'h0);
      chk("ill_both_err", rsp_err, 2'b10);
      chk("ill_both_req", mem_req, 0);
      handshake();

      // Timeout: mem_req high for exactly 15 cycles
      issue(1, 0, 3'b010, 32'h0, 32'h0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!mem_req) break;
         n++;
         tick();
      end
      chk("tmo_cycles", n, 15);
      chk("tmo_valid", rsp_valid, 1);
      chk("tmo_err", rsp_err, 2'b11);
      chk("tmo_rdata", rsp_rdata, 0);
      ack_with(32'hFFFF_FFFF);
      chk("late_ack_valid", rsp_valid, 1);
      chk("late_ack_err", rsp_err, 2'b11);
      chk("late_ack_rdata", rsp_rdata, 0);
      chk("late_ack_req", mem_req, 0);
      handshake();

      // Held response, then back-to-back request
      issue(1, 0, 3'b010, 32'h4, 32'h0);
      ack_with(32'hCAFE_F00D);
      for (int i = 0; i < 4; i++) begin
         chk("hold_valid", rsp_valid, 1);
         chk("hold_rdata", rsp_rdata, 32'hCAFE_F00D);
         chk("hold_rdy", req_ready, 0);
         tick();
      end
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      is_load   = 1'b1;
      funct3    = 3'b100;
      addr      = 32'h1;
      tick();
      rsp_ready = 1'b0;
      chk("b2b_no_accept", mem_req, 0);
      chk("b2b_valid", rsp_valid, 0);
      chk("b2b_rdy", req_ready, 1);
      tick();
      req_valid = 1'b0;
      is_load   = 1'b0;
      chk("b2b_req", mem_req, 1);
      chk("b2b_addr", mem_addr, 0);
      ack_with(32'h0000_AB00);
      chk("b2b_rdata", rsp_rdata, 32'h0000_00AB);
      handshake();

      // Asynchronous reset while in BUS
      issue(0, 1, 3'b010, 32'h10, 32'h11);
      chk("ar_req", mem_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_req_drop", mem_req, 0);
      chk("ar_we", mem_we, 0);
      chk("ar_addr", mem_addr, 0);
      chk("ar_be", mem_be, 0);
      chk("ar_wdata", mem_wdata, 0);
      chk("ar_valid", rsp_valid, 0);
      chk("ar_rdy", req_ready, 1);
      tick();
      rst_n = 1'b1;
      tick();
      issue(1, 0, 3'b010, 32'h8, 32'h0);
      chk("post_addr", mem_addr, 5'h02);
      ack_with(32'h55AA_55AA);
      chk("post_rdata", rsp_rdata, 32'h55AA_55AA);
      chk("post_err", rsp_err, 0);
      handshake();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
